// File: rtl/commit_trace_buf.sv
// Commit trace buffer: a small FIFO of committed-instruction records
// for a lockstep checker, with a clock-gate request as it nears full.
`ifndef MEMD_SIZE_LOG
`define MEMD_SIZE_LOG 16
`endif
`ifndef ROB_SIZE_LOG
`define ROB_SIZE_LOG 5
`endif

module commit_trace_buf #(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = `MEMD_SIZE_LOG,
    parameter int ROB_W  = `ROB_SIZE_LOG,
    parameter int SEQ_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    c_valid,
    input  logic                    c_mem_valid,
    input  logic                    c_mem_rdwt,
    input  logic                    c_is_br,
    input  logic                    c_taken,
    input  logic                    c_squash,
    input  logic [ADDR_W-1:0]       c_mem_addr,
    input  logic [ROB_W-1:0]        c_rob_idx,
    input  logic                    flush,
    input  logic                    out_ready,
    output logic                    out_valid,
    output logic                    out_mem_valid,
    output logic                    out_mem_rdwt,
    output logic                    out_is_br,
    output logic                    out_taken,
    output logic                    out_squash,
    output logic [ADDR_W-1:0]       out_mem_addr,
    output logic [ROB_W-1:0]        out_rob_idx,
    output logic [SEQ_W-1:0]        out_seq,
    output logic                    stall_req,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    overflow
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef struct packed {
        logic              mem_valid;
        logic              mem_rdwt;
        logic              is_br;
        logic              taken;
        logic              squash;
        logic [ADDR_W-1:0] mem_addr;
        logic [ROB_W-1:0]  rob_idx;
        logic [SEQ_W-1:0]  seq;
    } rec_t;

    rec_t             mem [DEPTH];
    rec_t             wr_rec;
    rec_t             head;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [SEQ_W-1:0] seq;
    logic             full;
    logic             pop;
    logic             push_ok;
    logic             drop;

    assign full    = (count == CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign pop     = out_valid && out_ready;
    // A full buffer still accepts a push when the head leaves this cycle.
    assign push_ok = c_valid && (!full || pop);
    assign drop    = c_valid && full && !pop;

    assign stall_req = (count >= CNT_W'(DEPTH - 1));

    always_comb begin
        wr_rec           = '0;
        wr_rec.mem_valid = c_mem_valid;
        wr_rec.mem_rdwt  = c_mem_rdwt;
        wr_rec.is_br     = c_is_br;
        wr_rec.taken     = c_taken;
        wr_rec.squash    = c_squash;
        wr_rec.mem_addr  = c_mem_addr;
        wr_rec.rob_idx   = c_rob_idx;
        wr_rec.seq       = seq;
    end

    assign head          = mem[rd_ptr];
    assign out_mem_valid = head.mem_valid;
    assign out_mem_rdwt  = head.mem_rdwt;
    assign out_is_br     = head.is_br;
    assign out_taken     = head.taken;
    assign out_squash    = head.squash;
    assign out_mem_addr  = head.mem_addr;
    assign out_rob_idx   = head.rob_idx;
    assign out_seq       = head.seq;

    // Storage needs no reset; only the head with out_valid is observed.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) begin
            mem[wr_ptr] <= wr_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            seq      <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            seq    <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                seq    <= seq + SEQ_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (push_ok && !pop) begin
                count <= count + CNT_W'(1);
            end else if (pop && !push_ok) begin
                count <= count - CNT_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_commit_trace_buf.sv
// Bench for commit_trace_buf: table vectors, directed corner
// sequences and random traffic against a queue-based model.
module tb_commit_trace_buf;

    localparam int DEPTH  = 4;
    localparam int ADDR_W = 16;
    localparam int ROB_W  = 5;
    localparam int SEQ_W  = 8;
    localparam int CW     = 3;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              c_valid = 1'b0;
    logic              c_mem_valid = 1'b0;
    logic              c_mem_rdwt = 1'b0;
    logic              c_is_br = 1'b0;
    logic              c_taken = 1'b0;
    logic              c_squash = 1'b0;
    logic [ADDR_W-1:0] c_mem_addr = '0;
    logic [ROB_W-1:0]  c_rob_idx = '0;
    logic              flush = 1'b0;
    logic              out_ready = 1'b0;
    logic              out_valid;
    logic              out_mem_valid;
    logic              out_mem_rdwt;
    logic              out_is_br;
    logic              out_taken;
    logic              out_squash;
    logic [ADDR_W-1:0] out_mem_addr;
    logic [ROB_W-1:0]  out_rob_idx;
    logic [SEQ_W-1:0]  out_seq;
    logic              stall_req;
    logic [CW-1:0]     count;
    logic              overflow;

    commit_trace_buf #(
        .DEPTH(DEPTH), .ADDR_W(ADDR_W), .ROB_W(ROB_W), .SEQ_W(SEQ_W)
    ) dut (
        .clk(clk), .rst(rst),
        .c_valid(c_valid), .c_mem_valid(c_mem_valid),
        .c_mem_rdwt(c_mem_rdwt), .c_is_br(c_is_br),
        .c_taken(c_taken), .c_squash(c_squash),
        .c_mem_addr(c_mem_addr), .c_rob_idx(c_rob_idx),
        .flush(flush), .out_ready(out_ready),
        .out_valid(out_valid), .out_mem_valid(out_mem_valid),
        .out_mem_rdwt(out_mem_rdwt), .out_is_br(out_is_br),
        .out_taken(out_taken), .out_squash(out_squash),
        .out_mem_addr(out_mem_addr), .out_rob_idx(out_rob_idx),
        .out_seq(out_seq), .stall_req(stall_req),
        .count(count), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]        attr;
        logic [ADDR_W-1:0] addr;
        logic [ROB_W-1:0]  rob;
        logic [SEQ_W-1:0]  seq;
    } rec_t;

    typedef struct {
        logic              cv;
        logic              rdy;
        logic              fl;
        logic [ADDR_W-1:0] addr;
        int                cnt;
        logic              vld;
        int                seq;
        logic [ADDR_W-1:0] haddr;
        logic              stall;
        logic              ovf;
    } vec_t;

    rec_t q[$];
    int   m_seq = 0;
    logic m_ovf = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    vec_t tbl[11];

    // Model: the buffer is a bounded queue; evaluated with pre-edge inputs.
    task automatic model_clk();
        rec_t r;
        bit   do_pop;
        int   sz;
        if (flush) begin
            q.delete();
            m_seq = 0;
        end else begin
            sz = q.size();
            do_pop = (sz != 0) && out_ready;
            if (do_pop) void'(q.pop_front());
            if (c_valid) begin
                if (sz < DEPTH || do_pop) begin
                    r.attr = {c_mem_valid, c_mem_rdwt, c_is_br, c_taken, c_squash};
                    r.addr = c_mem_addr;
                    r.rob  = c_rob_idx;
                    r.seq  = SEQ_W'(m_seq);
                    q.push_back(r);
                    m_seq = (m_seq + 1) % 256;
                end else begin
                    m_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_seq = 0;
        m_ovf = 1'b0;
    endtask

    task automatic check(string name);
        logic [5:0] act;
        logic [5:0] exp;
        logic [ADDR_W+ROB_W+SEQ_W+4:0] ah;
        logic [ADDR_W+ROB_W+SEQ_W+4:0] eh;
        bit bad;
        vectors++;
        act = {out_valid, count, stall_req, overflow};
        exp = {q.size() != 0, CW'(q.size()), q.size() >= DEPTH - 1, m_ovf};
        bad = (act !== exp);
        ah = '0;
        eh = '0;
        if (q.size() != 0) begin
            ah = {out_mem_valid, out_mem_rdwt, out_is_br, out_taken, out_squash,
                  out_mem_addr, out_rob_idx, out_seq};
            eh = {q[0].attr, q[0].addr, q[0].rob, q[0].seq};
            if (ah !== eh) bad = 1'b1;
        end
        if (bad) begin
            miscompares++;
            $display("FAIL %s: vld/cnt/stall/ovf=%b head=%h, expected %b head=%h",
                     name, act, ah, exp, eh);
        end
    endtask

    task automatic expect_int(string name, int act, int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(logic cv, logic rdy, logic fl, logic [ADDR_W-1:0] a);
        c_valid     = cv;
        out_ready   = rdy;
        flush       = fl;
        c_mem_addr  = a;
        c_mem_valid = 1'($urandom);
        c_mem_rdwt  = 1'($urandom);
        c_is_br     = 1'($urandom);
        c_taken     = 1'($urandom);
        c_squash    = 1'($urandom);
        c_rob_idx   = ROB_W'($urandom);
    endtask

    task automatic step(string name);
        model_clk();
        @(posedge clk);
        #1;
        check(name);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        #1;
        model_reset();
        check("reset");
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        bit   saw_wrap;
        logic [SEQ_W-1:0] prev;

        tbl[0]  = '{1'b1, 1'b0, 1'b0, 16'd5,  1, 1'b1, 0, 16'd5,  1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 16'd6,  2, 1'b1, 0, 16'd5,  1'b0, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 16'd7,  3, 1'b1, 0, 16'd5,  1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 1'b0, 16'd8,  4, 1'b1, 0, 16'd5,  1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b0, 1'b0, 16'd9,  4, 1'b1, 0, 16'd5,  1'b1, 1'b1};
        tbl[5]  = '{1'b0, 1'b1, 1'b0, 16'd0,  3, 1'b1, 1, 16'd6,  1'b1, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 1'b0, 16'd0,  2, 1'b1, 2, 16'd7,  1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 16'd0,  1, 1'b1, 3, 16'd8,  1'b0, 1'b1};
        tbl[8]  = '{1'b0, 1'b1, 1'b0, 16'd0,  0, 1'b0, 0, 16'd0,  1'b0, 1'b1};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 16'd0,  0, 1'b0, 0, 16'd0,  1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 16'd20, 1, 1'b1, 4, 16'd20, 1'b0, 1'b1};

        do_reset();
        for (int i = 0; i < 11; i++) begin
            drive(tbl[i].cv, tbl[i].rdy, tbl[i].fl, tbl[i].addr);
            step("table_model");
            vectors++;
            if (int'(count) != tbl[i].cnt || out_valid !== tbl[i].vld ||
                stall_req !== tbl[i].stall || overflow !== tbl[i].ovf ||
                (tbl[i].vld && (int'(out_seq) != tbl[i].seq ||
                                out_mem_addr !== tbl[i].haddr))) begin
                miscompares++;
                $display("FAIL table[%0d]: cnt=%0d vld=%b seq=%0d addr=%0d stall=%b ovf=%b, expected cnt=%0d vld=%b seq=%0d addr=%0d stall=%b ovf=%b",
                         i, count, out_valid, out_seq, out_mem_addr, stall_req, overflow,
                         tbl[i].cnt, tbl[i].vld, tbl[i].seq, tbl[i].haddr,
                         tbl[i].stall, tbl[i].ovf);
            end
        end

        // Full buffer with simultaneous push and pop.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, ADDR_W'(50 + i));
            step("fill");
        end
        drive(1'b1, 1'b1, 1'b0, 16'd100);
        step("full_push_pop");
        expect_int("full_pp_count", int'(count), 4);
        expect_int("full_pp_ovf", int'(overflow), 0);
        for (int i = 0; i < 3; i++) begin
            drive(1'b0, 1'b1, 1'b0, '0);
            step("drain");
        end
        expect_int("full_pp_seq", int'(out_seq), 4);
        expect_int("full_pp_addr", int'(out_mem_addr), 100);

        // Streaming push+pop through a sequence-number wrap.
        do_reset();
        saw_wrap = 1'b0;
        prev = '0;
        for (int i = 0; i < 300; i++) begin
            drive(1'b1, 1'b1, 1'b0, ADDR_W'($urandom));
            step("stream");
            expect_int("stream_cnt_le1", int'(count <= 1), 1);
            expect_int("stream_valid", int'(out_valid), 1);
            if (i > 0 && prev == 8'd255 && out_seq == 8'd0) saw_wrap = 1'b1;
            prev = out_seq;
        end
        expect_int("stream_seq_wrap", int'(saw_wrap), 1);

        // Flush beats a same-cycle push and pop.
        do_reset();
        drive(1'b1, 1'b0, 1'b0, 16'd1);
        step("pre_flush");
        drive(1'b1, 1'b0, 1'b0, 16'd2);
        step("pre_flush");
        drive(1'b1, 1'b1, 1'b1, 16'd3);
        step("flush");
        expect_int("flush_count", int'(count), 0);
        expect_int("flush_valid", int'(out_valid), 0);
        drive(1'b1, 1'b0, 1'b0, 16'd4);
        step("post_flush");
        expect_int("post_flush_seq", int'(out_seq), 0);

        // Asynchronous reset mid-cycle with stored records and overflow.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, 1'b0, 1'b0, ADDR_W'(i));
            step("ovf_fill");
        end
        drive(1'b0, 1'b1, 1'b0, '0);
        step("ovf_pop");
        expect_int("pre_rst_count", int'(count), 3);
        expect_int("pre_rst_ovf", int'(overflow), 1);
        #2;
        rst = 1'b0;
        drive(1'b0, 1'b0, 1'b0, '0);
        #1;
        model_reset();
        expect_int("async_count", int'(count), 0);
        expect_int("async_ovf", int'(overflow), 0);
        expect_int("async_valid", int'(out_valid), 0);
        expect_int("async_stall", int'(stall_req), 0);
        @(negedge clk);
        rst = 1'b1;
        drive(1'b1, 1'b0, 1'b0, 16'd77);
        step("post_rst_push");
        expect_int("post_rst_seq", int'(out_seq), 0);

        // Random traffic.
        do_reset();
        for (int i = 0; i < 600; i++) begin
            drive(1'(($urandom % 4) != 0), 1'(($urandom % 3) == 0),
                  1'(($urandom % 64) == 0), ADDR_W'($urandom));
            step("random");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
